lsu_mem_ctrl: RTL

Load/store access controller on the CPU side of the dual-port RAM data port. It accepts one CPU memory request at a time (byte/half/word, load or store) and drives the RAM's word-aligned, word-only data port (`ce`/addr/wdata/`we`, combinational read, posedge write). It extracts and sign/zero-extends sub-word load data, and performs read-modify-write for byte and half stores. Byte order is big-endian: byte offset 0 is bits [31:24] of the RAM word.

---
 rtl/lsu_mem_ctrl_if.sv | 36 +++
 rtl/lsu_mem_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// CPU request/response and RAM data-port signals of the load/store controller.
// The slave modport is the controller's view; master is the CPU/RAM side.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  req_we_in;
    logic [1:0]            req_size_in;
    logic                  req_signed_in;
    logic [ADDR_WIDTH-1:0] req_addr_in;
    logic [DATA_WIDTH-1:0] req_wdata_in;
    logic                  resp_valid_out;
    logic [DATA_WIDTH-1:0] resp_rdata_out;
    logic                  resp_err_out;
    logic                  ce_out;
    logic                  mem_we_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport slave (
        input  req_valid_in, req_we_in, req_size_in, req_signed_in, req_addr_in,
               req_wdata_in, mem_data_in,
        output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
               ce_out, mem_we_out, mem_addr_out, mem_data_out
    );

    modport master (
        output req_valid_in, req_we_in, req_size_in, req_signed_in, req_addr_in,
               req_wdata_in, mem_data_in,
        input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
               ce_out, mem_we_out, mem_addr_out, mem_data_out
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a word-only, big-endian RAM data port:
// sub-word load extraction/extension and read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
    parameter int CHECK_ALIGN = 1,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32
) (
    input logic           clk_in,
    input logic           rst_in,
    lsu_mem_ctrl_if.slave bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                state;
    logic                  rdy_r, ce_r, mwe_r, rvld_r, err_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [1:0]            size_r;
    logic                  sgn_r, st_r;
    logic [DATA_WIDTH-1:0] wdata_r, rdata_r, merge_r;
    logic                  accept, req_err, misaligned;
    logic [ADDR_WIDTH-1:0] req_addr;

    // Byte offset 0 is the most significant byte of the word.
    function automatic logic [DATA_WIDTH-1:0] extract_lane(
        input logic [DATA_WIDTH-1:0] word, input logic [1:0] size,
        input logic [1:0] off, input logic sgn);
        int                    top;
        logic [DATA_WIDTH-1:0] res;
        top = DATA_WIDTH - 1 - 8 * int'(off);
        res = '0;
        if (size == SZ_BYTE) begin
            res[7:0] = word[top -: 8];
            if (sgn) res[DATA_WIDTH-1:8] = {(DATA_WIDTH-8){word[top]}};
        end else if (size == SZ_HALF) begin
            res[15:0] = word[top -: 16];
            if (sgn) res[DATA_WIDTH-1:16] = {(DATA_WIDTH-16){word[top]}};
        end else begin
            res = word;
        end
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lane(
        input logic [DATA_WIDTH-1:0] word, input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0] size, input logic [1:0] off);
        int                    top;
        logic [DATA_WIDTH-1:0] res;
        top = DATA_WIDTH - 1 - 8 * int'(off);
        res = word;
        if (size == SZ_BYTE)      res[top -: 8]  = wdata[7:0];
        else if (size == SZ_HALF) res[top -: 16] = wdata[15:0];
        else                      res = wdata;
        return res;
    endfunction

    always_comb begin
        misaligned = ((bus.req_size_in == SZ_HALF) && bus.req_addr_in[0]) ||
                     ((bus.req_size_in == SZ_WORD) && (bus.req_addr_in[1:0] != 2'b00));
        req_err    = (bus.req_size_in == SZ_RSVD) || ((CHECK_ALIGN != 0) && misaligned);
        req_addr   = bus.req_addr_in;
        if (CHECK_ALIGN == 0) begin
            if (bus.req_size_in == SZ_HALF) req_addr[0]   = 1'b0;
            if (bus.req_size_in == SZ_WORD) req_addr[1:0] = 2'b00;
        end
    end

    assign accept             = bus.req_valid_in && rdy_r;
    assign bus.req_ready_out  = rdy_r && !rst_in;
    assign bus.ce_out         = ce_r;
    assign bus.mem_we_out     = mwe_r;
    assign bus.mem_addr_out   = ce_r ? {addr_r[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_data_out   = mwe_r ? merge_r : '0;
    assign bus.resp_valid_out = rvld_r;
    assign bus.resp_rdata_out = rvld_r ? rdata_r : '0;
    assign bus.resp_err_out   = rvld_r && err_r;

    // Control flags are registered alongside the state so reset clears every
    // output at once, including mid-access.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state  <= IDLE;
            rdy_r  <= 1'b1;
            ce_r   <= 1'b0;
            mwe_r  <= 1'b0;
            rvld_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rdy_r <= 1'b0;
                    err_r <= req_err;
                    if (req_err) begin
                        state  <= RESP;
                        rvld_r <= 1'b1;
                    end else if (bus.req_we_in && (bus.req_size_in == SZ_WORD)) begin
                        state <= WR;
                        ce_r  <= 1'b1;
                        mwe_r <= 1'b1;
                    end else begin
                        state <= RD;
                        ce_r  <= 1'b1;
                    end
                end
                RD: if (st_r) begin
                    state <= WR;
                    mwe_r <= 1'b1;
                end else begin
                    state  <= RESP;
                    ce_r   <= 1'b0;
                    rvld_r <= 1'b1;
                end
                WR: begin
                    state  <= RESP;
                    ce_r   <= 1'b0;
                    mwe_r  <= 1'b0;
                    rvld_r <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    rvld_r <= 1'b0;
                    rdy_r  <= 1'b1;
                end
            endcase
        end
    end

    // Request fields and the data path need no reset: every output that shows
    // them is gated by a control flag.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            addr_r  <= req_addr;
            size_r  <= bus.req_size_in;
            sgn_r   <= bus.req_signed_in;
            st_r    <= bus.req_we_in;
            wdata_r <= bus.req_wdata_in;
            rdata_r <= '0;
            merge_r <= bus.req_wdata_in;
        end else if (state == RD) begin
            if (st_r) merge_r <= merge_lane(bus.mem_data_in, wdata_r, size_r, addr_r[1:0]);
            else      rdata_r <= extract_lane(bus.mem_data_in, size_r, addr_r[1:0], sgn_r);
        end
    end
endmodule
